// File: rtl/mux_rr_sequencer_if.sv
// Purpose: request/capture bundle between the lab datapath and the mux sequencer.
// Latency: none, this is wiring only.
// Backpressure: none. A source holds its request level until it sees its grant complete.
interface mux_rr_sequencer_if;
  logic req_a;    // source A requests the multiplexer
  logic req_b;    // source B requests the multiplexer
  logic mux_s;    // multiplexer output s, fed back for capture
  logic select;   // multiplexer select: 0 passes A, 1 passes B
  logic gnt_a;    // A currently granted
  logic gnt_b;    // B currently granted
  logic q;        // last captured multiplexer value
  logic q_valid;  // one-cycle pulse, q updated this cycle
  logic q_src;    // source of the value in q (0 = A, 1 = B)

  // Requesting side: the datapath sources and the multiplexer feedback.
  modport master (
    output req_a, req_b, mux_s,
    input  select, gnt_a, gnt_b, q, q_valid, q_src
  );

  // Sequencer side.
  modport slave (
    input  req_a, req_b, mux_s,
    output select, gnt_a, gnt_b, q, q_valid, q_src
  );
endinterface

// File: rtl/mux_rr_sequencer.sv
// Purpose: round-robin arbiter driving the NOR 2:1 mux select; captures mux output after HOLD cycles.
// Latency: grant 1 cycle after request, capture HOLD cycles after grant entry, q_valid the cycle after.
// Backpressure: the losing source waits while its request is held; dropping a request aborts its grant.
module mux_rr_sequencer #(
  parameter int HOLD = 2
) (
  input logic             clk,
  input logic             reset,
  mux_rr_sequencer_if.slave bus
);

  // Value of the hold counter on the edge that completes a grant.
  localparam logic [3:0] LP_LAST = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_last;        // last source served: 0 = A, 1 = B
  logic       w_last_nxt;
  logic       r_select;
  logic       w_select_nxt;
  logic       r_gnt_a;
  logic       w_gnt_a_nxt;
  logic       r_gnt_b;
  logic       w_gnt_b_nxt;
  logic       r_q;
  logic       w_q_nxt;
  logic       r_q_valid;
  logic       w_q_valid_nxt;
  logic       r_q_src;
  logic       w_q_src_nxt;

  // Pick the next grant. On a tie the source that was not served last wins.
  function automatic state_t f_arb(input logic i_a, input logic i_b, input logic i_last);
    state_t w_s;
    w_s = IDLE;
    if (i_a && i_b) begin
      w_s = i_last ? GRANT_A : GRANT_B;
    end else if (i_a) begin
      w_s = GRANT_A;
    end else if (i_b) begin
      w_s = GRANT_B;
    end
    return w_s;
  endfunction

  // Next-state logic: arbitration, hold counting, capture and abort.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_last_nxt    = r_last;
    w_q_nxt       = r_q;
    w_q_src_nxt   = r_q_src;
    w_q_valid_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_nxt = f_arb(bus.req_a, bus.req_b, r_last);
        w_cnt_nxt   = 4'd0;
      end
      GRANT_A: begin
        if (!bus.req_a) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == LP_LAST) begin
          // Capture, then re-arbitrate immediately with A marked as served.
          w_q_nxt       = bus.mux_s;
          w_q_src_nxt   = 1'b0;
          w_q_valid_nxt = 1'b1;
          w_last_nxt    = 1'b0;
          w_state_nxt   = f_arb(bus.req_a, bus.req_b, 1'b0);
          w_cnt_nxt     = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      GRANT_B: begin
        if (!bus.req_b) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == LP_LAST) begin
          // Capture, then re-arbitrate immediately with B marked as served.
          w_q_nxt       = bus.mux_s;
          w_q_src_nxt   = 1'b1;
          w_q_valid_nxt = 1'b1;
          w_last_nxt    = 1'b1;
          w_state_nxt   = f_arb(bus.req_a, bus.req_b, 1'b1);
          w_cnt_nxt     = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase

    // select only moves when a grant is entered and holds its value through IDLE.
    w_select_nxt = r_select;
    if (w_state_nxt == GRANT_A) begin
      w_select_nxt = 1'b0;
    end else if (w_state_nxt == GRANT_B) begin
      w_select_nxt = 1'b1;
    end
    w_gnt_a_nxt = (w_state_nxt == GRANT_A);
    w_gnt_b_nxt = (w_state_nxt == GRANT_B);
  end

  // State and output registers. Reset leaves last_served = B so A wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_last    <= 1'b1;
      r_select  <= 1'b0;
      r_gnt_a   <= 1'b0;
      r_gnt_b   <= 1'b0;
      r_q       <= 1'b0;
      r_q_valid <= 1'b0;
      r_q_src   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_last_nxt;
      r_select  <= w_select_nxt;
      r_gnt_a   <= w_gnt_a_nxt;
      r_gnt_b   <= w_gnt_b_nxt;
      r_q       <= w_q_nxt;
      r_q_valid <= w_q_valid_nxt;
      r_q_src   <= w_q_src_nxt;
    end
  end

  assign bus.select  = r_select;
  assign bus.gnt_a   = r_gnt_a;
  assign bus.gnt_b   = r_gnt_b;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.q_src   = r_q_src;

endmodule
